// File: rtl/gpio_target_if.sv
// Bus target port bundle for gpio_target: request/write-data from the master,
// read data, completion and ready from the target.
interface gpio_target_if;
   logic [15:0] target_addr_in;
   logic        target_addr_in_valid;
   logic [7:0]  target_data_in;
   logic        target_data_in_valid;
   logic        target_rw;
   logic [7:0]  target_data_out;
   logic        target_data_out_valid;
   logic        target_ack;
   logic        target_ready;

   modport master (
      output target_addr_in, target_addr_in_valid, target_data_in,
             target_data_in_valid, target_rw,
      input  target_data_out, target_data_out_valid, target_ack, target_ready
   );

   modport slave (
      input  target_addr_in, target_addr_in_valid, target_data_in,
             target_data_in_valid, target_rw,
      output target_data_out, target_data_out_valid, target_ack, target_ready
   );
endinterface

// File: rtl/gpio_target.sv
// Register-mapped GPIO responder: LEDs, synchronised buttons, scratch, write counter, ID.
// Optional 16-bit cycle timer with high-byte shadow when GPIO_TARGET_TIMER_EN is defined.
module gpio_target #(
   parameter int unsigned INTERNAL_ADDR_BITS = 11,
   parameter int unsigned WAIT_STATES        = 0,
   parameter logic [7:0]  ID_VALUE           = 8'hA7
) (
   input  logic         clk,
   input  logic         rst_n,
   gpio_target_if.slave bus,
   input  logic [7:0]   btn_in,
   output logic [7:0]   led_out,
   output logic [7:0]   target_last_write
);
   localparam int unsigned AW = INTERNAL_ADDR_BITS;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {IDLE, WDATA, WAIT, RESP} state_e;

   state_e        state_q, state_d;
   logic [AW-1:0] off_q, off_d;
   logic          rw_q, rw_d;
   logic [7:0]    wdata_q, wdata_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0]    led_q, led_d, scratch_q, scratch_d;
   logic [7:0]    wrcnt_q, wrcnt_d, last_q, last_d;
   logic [7:0]    dout_q, dout_d;
   logic          dvalid_q, dvalid_d, ack_q, ack_d, ready_q, ready_d;
   logic [7:0]    btn_meta_q, btn_sync_q;
   logic [7:0]    rd_data_c;
   logic          in_range_c, resp_go_c;
   logic [15:0]   unused_addr;

   assign unused_addr = bus.target_addr_in;

`ifdef GPIO_TARGET_TIMER_EN
   logic [15:0] timer_q;
   logic [7:0]  shadow_q, shadow_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q  <= 16'h0000;
         shadow_q <= 8'h00;
      end else begin
         timer_q  <= timer_q + 16'd1;
         shadow_q <= shadow_d;
      end
   end
`endif

   // Two-flop synchroniser for the asynchronous button levels
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_meta_q <= 8'h00;
         btn_sync_q <= 8'h00;
      end else begin
         btn_meta_q <= btn_in;
         btn_sync_q <= btn_meta_q;
      end
   end

   assign in_range_c = ((off_q >> 3) == '0);

   always_comb begin
      rd_data_c = 8'h00;
      if (in_range_c) begin
         case (off_q[2:0])
            3'd0:    rd_data_c = led_q;
            3'd2:    rd_data_c = btn_sync_q;
`ifdef GPIO_TARGET_TIMER_EN
            3'd3:    rd_data_c = timer_q[7:0];
            3'd4:    rd_data_c = shadow_q;
`endif
            3'd5:    rd_data_c = scratch_q;
            3'd6:    rd_data_c = wrcnt_q;
            3'd7:    rd_data_c = ID_VALUE;
            default: rd_data_c = 8'h00;
         endcase
      end
   end

   // Next-state, register commit and registered-output computation
   always_comb begin
      state_d   = state_q;
      off_d     = off_q;
      rw_d      = rw_q;
      wdata_d   = wdata_q;
      cnt_d     = cnt_q;
      led_d     = led_q;
      scratch_d = scratch_q;
      wrcnt_d   = wrcnt_q;
      last_d    = last_q;
      dout_d    = 8'h00;
      dvalid_d  = 1'b0;
      ack_d     = 1'b0;
      resp_go_c = 1'b0;
`ifdef GPIO_TARGET_TIMER_EN
      shadow_d  = shadow_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.target_addr_in_valid) begin
               off_d = bus.target_addr_in[AW-1:0];
               rw_d  = bus.target_rw;
               cnt_d = '0;
               if (!bus.target_rw) begin
                  state_d = WAIT;
               end else if (bus.target_data_in_valid) begin
                  wdata_d = bus.target_data_in;
                  state_d = WAIT;
               end else begin
                  state_d = WDATA;
               end
            end
         end
         WDATA: begin
            if (bus.target_data_in_valid) begin
               wdata_d = bus.target_data_in;
               cnt_d   = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (cnt_q == CW'(WAIT_STATES)) begin
               state_d   = RESP;
               resp_go_c = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Response registers load on the edge entering RESP so they are visible during it
      if (resp_go_c) begin
         ack_d = 1'b1;
         if (rw_q) begin
            if (in_range_c) begin
               wrcnt_d = wrcnt_q + 8'd1;
               last_d  = wdata_q;
               case (off_q[2:0])
                  3'd0:    led_d     = wdata_q;
                  3'd1:    led_d     = led_q ^ wdata_q;
                  3'd5:    scratch_d = wdata_q;
                  default: ;
               endcase
            end
         end else begin
            dout_d   = rd_data_c;
            dvalid_d = 1'b1;
`ifdef GPIO_TARGET_TIMER_EN
            if (in_range_c && (off_q[2:0] == 3'd3)) shadow_d = timer_q[15:8];
`endif
         end
      end
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         off_q     <= '0;
         rw_q      <= 1'b0;
         wdata_q   <= 8'h00;
         cnt_q     <= '0;
         led_q     <= 8'h00;
         scratch_q <= 8'h00;
         wrcnt_q   <= 8'h00;
         last_q    <= 8'h00;
         dout_q    <= 8'h00;
         dvalid_q  <= 1'b0;
         ack_q     <= 1'b0;
         ready_q   <= 1'b1;
      end else begin
         state_q   <= state_d;
         off_q     <= off_d;
         rw_q      <= rw_d;
         wdata_q   <= wdata_d;
         cnt_q     <= cnt_d;
         led_q     <= led_d;
         scratch_q <= scratch_d;
         wrcnt_q   <= wrcnt_d;
         last_q    <= last_d;
         dout_q    <= dout_d;
         dvalid_q  <= dvalid_d;
         ack_q     <= ack_d;
         ready_q   <= ready_d;
      end
   end

   assign bus.target_data_out       = dout_q;
   assign bus.target_data_out_valid = dvalid_q;
   assign bus.target_ack            = ack_q;
   assign bus.target_ready          = ready_q;
   assign led_out                   = led_q;
   assign target_last_write         = last_q;
endmodule

// File: tb/tb_gpio_target.sv
// Bench for gpio_target: two instances (0 and 3 wait states), a transaction-level
// register/timing model checked every cycle, plus literal expectations.
module tb_gpio_target;
   localparam int unsigned WS1 = 3;

   logic       clk = 1'b0;
   logic       rst0_n, rst1_n;
   logic [7:0] btn;
   logic [7:0] led0, led1, last0, last1;

   gpio_target_if bus0();
   gpio_target_if bus1();

   gpio_target #(.INTERNAL_ADDR_BITS(11), .WAIT_STATES(0), .ID_VALUE(8'hA7)) dut0 (
      .clk(clk), .rst_n(rst0_n), .bus(bus0), .btn_in(btn),
      .led_out(led0), .target_last_write(last0));

   gpio_target #(.INTERNAL_ADDR_BITS(11), .WAIT_STATES(WS1), .ID_VALUE(8'hA7)) dut1 (
      .clk(clk), .rst_n(rst1_n), .bus(bus1), .btn_in(btn),
      .led_out(led1), .target_last_write(last1));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int acks1  = 0;

   // Model: per instance, the outstanding transaction's capture/response edges and register image
   int         m_cap [2];
   int         m_resp[2];
   int         m_rst_edge[2];
   logic       m_rw[2];
   logic [7:0] m_rdata[2], m_led_old[2], m_led_new[2], m_last_old[2], m_last_new[2];
   logic [7:0] m_scratch[2], m_wrc[2], m_shadow[2];

   function automatic int ws_of(input int d);
      return (d == 0) ? 0 : int'(WS1);
   endfunction

   task automatic chk(input string name, input int d, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual=%02h required=%02h cyc=%0d", name, d, act, exp, cyc);
      end
   endtask

   task automatic model_reset(input int d);
      m_cap[d] = -1; m_resp[d] = -1; m_rw[d] = 1'b1; m_rdata[d] = 8'h00;
      m_led_old[d] = 8'h00; m_led_new[d] = 8'h00;
      m_last_old[d] = 8'h00; m_last_new[d] = 8'h00;
      m_scratch[d] = 8'h00; m_wrc[d] = 8'h00; m_shadow[d] = 8'h00;
   endtask

   task automatic model_txn(input int d, input logic [15:0] addr, input logic rw,
                            input logic [7:0] data, input int cap, input int late);
      int off;
      int t;
      logic [15:0] tv;
      off = int'(addr & 16'h07FF);
      m_led_old[d]  = m_led_new[d];
      m_last_old[d] = m_last_new[d];
      m_cap[d]  = cap;
      m_resp[d] = cap + late + 1 + ws_of(d);
      m_rw[d]   = rw;
      m_rdata[d] = 8'h00;
      if (rw) begin
         if (off < 8) begin
            m_wrc[d] = m_wrc[d] + 8'd1;
            m_last_new[d] = data;
            if (off == 0) m_led_new[d] = data;
            if (off == 1) m_led_new[d] = m_led_new[d] ^ data;
            if (off == 5) m_scratch[d] = data;
         end
      end else begin
         case (off)
            0: m_rdata[d] = m_led_new[d];
            2: m_rdata[d] = btn;
`ifdef GPIO_TARGET_TIMER_EN
            3: begin
               t = m_resp[d] - m_rst_edge[d] - 1;
               tv = 16'(t);
               m_rdata[d]  = tv[7:0];
               m_shadow[d] = tv[15:8];
            end
            4: m_rdata[d] = m_shadow[d];
`endif
            5: m_rdata[d] = m_scratch[d];
            6: m_rdata[d] = m_wrc[d];
            7: m_rdata[d] = 8'hA7;
            default: m_rdata[d] = 8'h00;
         endcase
      end
   endtask

   task automatic cmp_dut(input int d, input logic ack, input logic dv, input logic [7:0] dout,
                          input logic rdy, input logic [7:0] led, input logic [7:0] last);
      logic e_ack, e_dv, e_rdy;
      e_ack = (cyc == m_resp[d]);
      e_dv  = e_ack && !m_rw[d];
      e_rdy = !(cyc >= m_cap[d] && cyc <= m_resp[d]);
      chk("ack", d, 8'(ack), 8'(e_ack));
      chk("dout_valid", d, 8'(dv), 8'(e_dv));
      chk("dout", d, dout, e_dv ? m_rdata[d] : 8'h00);
      chk("ready", d, 8'(rdy), 8'(e_rdy));
      chk("led", d, led, (cyc >= m_resp[d]) ? m_led_new[d] : m_led_old[d]);
      chk("last_write", d, last, (cyc >= m_resp[d]) ? m_last_new[d] : m_last_old[d]);
   endtask

   always @(negedge clk) begin
      cmp_dut(0, bus0.target_ack, bus0.target_data_out_valid, bus0.target_data_out,
              bus0.target_ready, led0, last0);
      cmp_dut(1, bus1.target_ack, bus1.target_data_out_valid, bus1.target_data_out,
              bus1.target_ready, led1, last1);
      if (bus1.target_ack) acks1++;
   end

   task automatic set_bus(input int d, input logic av, input logic [15:0] addr, input logic rw,
                          input logic dvld, input logic [7:0] data);
      if (d == 0) begin
         bus0.target_addr_in = addr; bus0.target_addr_in_valid = av; bus0.target_rw = rw;
         bus0.target_data_in = data; bus0.target_data_in_valid = dvld;
      end else begin
         bus1.target_addr_in = addr; bus1.target_addr_in_valid = av; bus1.target_rw = rw;
         bus1.target_data_in = data; bus1.target_data_in_valid = dvld;
      end
   endtask

   function automatic logic get_ack(input int d);
      if (d == 0) return bus0.target_ack;
      return bus1.target_ack;
   endfunction

   function automatic logic [7:0] get_dout(input int d);
      if (d == 0) return bus0.target_data_out;
      return bus1.target_data_out;
   endfunction

   // One transaction; called #1 after a rising edge with the target idle
   task automatic txn(input int d, input logic [15:0] addr, input logic rw, input logic [7:0] data,
                      input int late, input bit strobe, output logic [7:0] rd, output int lat);
      int cap;
      bit seen;
      cap = cyc + 1;
      model_txn(d, addr, rw, data, cap, late);
      set_bus(d, 1'b1, addr, rw, rw && (late == 0), data);
      @(posedge clk); #1;
      set_bus(d, 1'b0, addr, rw, 1'b0, data);
      if (strobe) begin
         set_bus(d, 1'b1, 16'h0005, 1'b0, 1'b0, 8'h00);
         @(posedge clk); #1;
         set_bus(d, 1'b0, 16'h0005, 1'b0, 1'b0, 8'h00);
      end
      if (rw && late > 0) begin
         repeat (late - 1) begin @(posedge clk); #1; end
         set_bus(d, 1'b0, addr, rw, 1'b1, data);
         @(posedge clk); #1;
         set_bus(d, 1'b0, addr, rw, 1'b0, data);
      end
      seen = 1'b0; lat = -1; rd = 8'h00;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(negedge clk);
         if (get_ack(d)) begin
            seen = 1'b1;
            lat  = cyc + 1 - cap;
            rd   = get_dout(d);
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL ack_timeout dut%0d actual=no_ack required=ack_within_40_cycles", d);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] rd;
      int lat, a1, cap;
      btn = 8'h00;
      set_bus(0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
      set_bus(1, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
      rst0_n = 1'b0; rst1_n = 1'b0;
      model_reset(0); model_reset(1);
      m_rst_edge[0] = 0; m_rst_edge[1] = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 0, 8'(bus0.target_ready), 8'h01);
      chk("rst_ack", 0, 8'(bus0.target_ack), 8'h00);
      chk("rst_led", 0, led0, 8'h00);
      chk("rst_dout", 1, bus1.target_data_out, 8'h00);
      rst0_n = 1'b1; rst1_n = 1'b1;
      m_rst_edge[0] = cyc; m_rst_edge[1] = cyc;
      @(posedge clk); #1;

      txn(0, 16'h0000, 1'b1, 8'h3C, 0, 1'b0, rd, lat);
      chk("wr_latency", 0, 8'(lat), 8'd2);
      chk("led_3c", 0, led0, 8'h3C);
      chk("last_3c", 0, last0, 8'h3C);
      txn(0, 16'h0006, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("wrcount_1", 0, rd, 8'h01);
      chk("rd_latency", 0, 8'(lat), 8'd2);

      txn(0, 16'h0001, 1'b1, 8'hFF, 0, 1'b0, rd, lat);
      chk("led_toggle", 0, led0, 8'hC3);
      txn(0, 16'h0001, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("rd_toggle", 0, rd, 8'h00);
      txn(0, 16'h0000, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("rd_led", 0, rd, 8'hC3);

      txn(0, 16'h0005, 1'b1, 8'h5A, 4, 1'b0, rd, lat);
      chk("late_latency", 0, 8'(lat), 8'd6);
      txn(0, 16'h0005, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("rd_scratch", 0, rd, 8'h5A);

      btn = 8'h81;
      repeat (3) @(posedge clk);
      #1;
      txn(0, 16'h0002, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("rd_btn", 0, rd, 8'h81);
      txn(0, 16'h0010, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("rd_unmapped", 0, rd, 8'h00);
      chk("unmapped_latency", 0, 8'(lat), 8'd2);
      txn(0, 16'h0010, 1'b1, 8'h77, 0, 1'b0, rd, lat);
      txn(0, 16'h0006, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("wrcount_unmapped", 0, rd, 8'h03);
      chk("last_unmapped", 0, last0, 8'h5A);
      txn(0, 16'h0007, 1'b1, 8'h11, 0, 1'b0, rd, lat);
      txn(0, 16'h0006, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("wrcount_ro", 0, rd, 8'h04);
      chk("last_ro", 0, last0, 8'h11);
      txn(0, 16'h0807, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("rd_id_upper_bits", 0, rd, 8'hA7);

      a1 = acks1;
      txn(1, 16'h0007, 1'b0, 8'h00, 0, 1'b1, rd, lat);
      chk("rd_id_ws3", 1, rd, 8'hA7);
      chk("ws3_latency", 1, 8'(lat), 8'd5);
      repeat (4) @(posedge clk);
      #1;
      chk("one_ack", 1, 8'(acks1 - a1), 8'd1);

      // Reset lands while dut1 is counting wait states on a write
      cap = cyc + 1;
      m_led_old[1] = m_led_new[1]; m_last_old[1] = m_last_new[1];
      m_cap[1] = cap; m_resp[1] = 1 << 30; m_rw[1] = 1'b1;
      set_bus(1, 1'b1, 16'h0000, 1'b1, 1'b1, 8'hEE);
      @(posedge clk); #1;
      set_bus(1, 1'b0, 16'h0000, 1'b1, 1'b0, 8'hEE);
      @(posedge clk); #1;
      rst1_n = 1'b0;
      model_reset(1);
      #1;
      chk("midrst_ready", 1, 8'(bus1.target_ready), 8'h01);
      chk("midrst_ack", 1, 8'(bus1.target_ack), 8'h00);
      chk("midrst_led", 1, led1, 8'h00);
      chk("midrst_last", 1, last1, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst1_n = 1'b1;
      m_rst_edge[1] = cyc;
      @(posedge clk); #1;
      txn(1, 16'h0006, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("midrst_wrcount", 1, rd, 8'h00);
      chk("midrst_led_after", 1, led1, 8'h00);

`ifdef GPIO_TARGET_TIMER_EN
      rst0_n = 1'b0;
      model_reset(0);
      @(posedge clk); #1;
      rst0_n = 1'b1;
      m_rst_edge[0] = cyc;
      while (cyc < m_rst_edge[0] + 254) begin @(posedge clk); #1; end
      txn(0, 16'h0003, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("timer_lo", 0, rd, 8'hFF);
      txn(0, 16'h0004, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("timer_hi_shadow", 0, rd, 8'h00);
      txn(0, 16'h0003, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      txn(0, 16'h0004, 1'b0, 8'h00, 0, 1'b0, rd, lat);
      chk("timer_hi_after_wrap", 0, rd, 8'h01);
`endif

      repeat (2) @(posedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
